// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing shared by the sync generator and the pixel layers
// (score, sprites, background) for their visible-area compares.
package vga_timing_pkg;

    localparam int unsigned ADDR_W     = 10;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned SYNC_DELAY = 1;

    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned H_FP       = 16;
    localparam int unsigned H_SYNC     = 96;
    localparam int unsigned H_BP       = 48;
    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned V_FP       = 10;
    localparam int unsigned V_SYNC     = 2;
    localparam int unsigned V_BP       = 33;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // True when addr lies in [lo, lo+len); done in 32 bits so no window edge can wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(addr) >= lo) && (32'(addr) < lo + len);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align sync/blank with the layers' registered pixels.
// DEPTH=0 is a straight wire.
module sync_delay_line #(
    parameter int unsigned    WIDTH     = 3,
    parameter int unsigned    DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift one stage per clk; reset loads the inactive value into every stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= RESET_VAL;
                end
            end else begin
                stage[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: clock divider to a pixel enable, horizontal/vertical counters,
// and delayed hsync/vsync/video_on. Defining VGA_SYNC_FRAME_CNT_EN adds the 16-bit
// frame_cnt output counting frames since reset.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV    = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
    parameter int unsigned SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] haddress,
    output logic [ADDR_W-1:0] vaddress,
    output logic              pix_tick,
    output logic              video_on,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int unsigned LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(FRAME_LINES - 1);

    // Elaboration-time sanity checks on the timing parameters.
    if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_bad_total
        $error("vga_sync_gen: H/V totals must be <= 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be 1..16");
    end
    if (SYNC_DELAY > 8) begin : g_bad_delay
        $error("vga_sync_gen: SYNC_DELAY must be 0..8");
    end

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              tick_d;
    logic [ADDR_W-1:0] haddr_d;
    logic [ADDR_W-1:0] vaddr_d;
    logic              wrap_d;

    logic              hs_raw;
    logic              vs_raw;
    logic              video_raw;
    logic [2:0]        sync_delayed;

    // Next-state for divider and counters; counters move only while pix_tick is high.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // pix_tick is registered so it reads 0 in reset even when CLK_DIV=1.
        tick_d  = (div_d == DIV_LAST);
        haddr_d = haddress;
        vaddr_d = vaddress;
        wrap_d  = 1'b0;
        if (pix_tick) begin
            if (haddress == H_LAST) begin
                haddr_d = '0;
                if (vaddress == V_LAST) begin
                    vaddr_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    vaddr_d = vaddress + 1'b1;
                end
            end else begin
                haddr_d = haddress + 1'b1;
            end
        end
    end

    // Timing state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            pix_tick    <= 1'b0;
            haddress    <= '0;
            vaddress    <= '0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_d;
            pix_tick    <= tick_d;
            haddress    <= haddr_d;
            vaddress    <= vaddr_d;
            frame_start <= wrap_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (wrap_d) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    // Undelayed sync and blanking decoded from the registered counters.
    always_comb begin
        hs_raw    = !in_window(haddress, H_VISIBLE + H_FP, H_SYNC);
        vs_raw    = !in_window(vaddress, V_VISIBLE + V_FP, V_SYNC);
        video_raw = in_window(haddress, 0, H_VISIBLE) && in_window(vaddress, 0, V_VISIBLE);
    end

    // Inactive value: video off, both syncs high.
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (3'b011)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({video_raw, vs_raw, hs_raw}),
        .dout  (sync_delayed)
    );

    assign {video_on, vsync, hsync} = sync_delayed;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a shrunken timing so several frames fit in the run.
// The reference model derives every output from the number of clk edges since reset.
module tb_vga_sync_gen;

    localparam int unsigned CD  = 3;
    localparam int unsigned HV  = 8;
    localparam int unsigned HFP = 2;
    localparam int unsigned HS  = 3;
    localparam int unsigned HBP = 2;
    localparam int unsigned VV  = 5;
    localparam int unsigned VFP = 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 2;
    localparam int unsigned SD  = 2;
    localparam int unsigned HT  = HV + HFP + HS + HBP;
    localparam int unsigned VT  = VV + VFP + VS + VBP;
    localparam int unsigned FRAME_CLK = CD * HT * VT;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        pix;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [9:0]  haddress;
    logic [9:0]  vaddress;
    logic        pix_tick;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vga_sync_gen #(
        .CLK_DIV    (CD),
        .H_VISIBLE  (HV),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_VISIBLE  (VV),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .SYNC_DELAY (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .haddress    (haddress),
        .vaddress    (vaddress),
        .pix_tick    (pix_tick),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs n clk edges after the last reset edge.
    function automatic exp_t model(input int unsigned n);
        exp_t        e;
        int unsigned p;
        int unsigned m;
        int unsigned hh;
        int unsigned vv;
        p     = n / CD;
        e.h   = 10'(p % HT);
        e.v   = 10'((p / HT) % VT);
        e.pix = ((n % CD) == CD - 1);
        if (n >= SD) begin
            m     = (n - SD) / CD;
            hh    = m % HT;
            vv    = (m / HT) % VT;
            e.hs  = !(hh >= HV + HFP && hh < HV + HFP + HS);
            e.vs  = !(vv >= VV + VFP && vv < VV + VFP + VS);
            e.vid = (hh < HV) && (vv < VV);
        end else begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.vid = 1'b0;
        end
        e.fs  = (n > 0) && (n % FRAME_CLK == 0);
        e.fc  = 16'(n / FRAME_CLK);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference side: each active edge pushes the state the DUT should now hold.
    initial begin
        int unsigned n;
        n = 0;
        forever begin
            @(posedge clk);
            if (reset) n = 0;
            else       n = n + 1;
            exp_q.push_back(model(n));
        end
    end

    // Monitor: on the falling edge compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("addr",        {12'd0, haddress, vaddress}, {12'd0, e.h, e.v});
                check("pix_tick",    32'(pix_tick), 32'(e.pix));
                check("sync_video",  {29'd0, video_on, vsync, hsync}, {29'd0, e.vid, e.vs, e.hs});
                check("frame_start", 32'(frame_start), 32'(e.fs));
`ifdef VGA_SYNC_FRAME_CNT_EN
                check("frame_cnt",   32'(frame_cnt), 32'(e.fc));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected stimulus to finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: long run over three whole frames, then random segments cut by mid-frame resets.
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3 * FRAME_CLK + 20) @(negedge clk);
        for (int seg = 0; seg < 10; seg++) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            reset = 1'b0;
            repeat ($urandom_range(20, 700)) @(negedge clk);
        end
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
